// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: writeback selects,
// FSM states and the packed control word driven onto the pipeline registers.
package pipe_ctrl_pkg;

  localparam logic [1:0]  WB_MEM    = 2'b00;
  localparam logic [1:0]  WB_ALU    = 2'b01;
  localparam logic [1:0]  WB_PC4    = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_flush;
    logic pc_sel;
  } ctrl_t;

  // Control words for each pipeline action, field order as in ctrl_t.
  localparam ctrl_t CTRL_NORMAL = 7'b1111_000;
  localparam ctrl_t CTRL_FREEZE = 7'b0000_000;
  localparam ctrl_t CTRL_REDIR  = 7'b1111_111;
  localparam ctrl_t CTRL_BUBBLE = 7'b0011_010;
  localparam ctrl_t CTRL_RESET  = 7'b0000_110;

  function automatic logic reg_match(logic [4:0] rd, logic [4:0] rs, logic uses);
    return uses && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [4:0]      ifid_rs1;
  logic [4:0]      ifid_rs2;
  logic            ifid_uses_rs1;
  logic            ifid_uses_rs2;
  logic [4:0]      idex_rd;
  logic            idex_RegWEn;
  logic [1:0]      idex_WBsel;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            mem_req;
  logic            mem_ready;

  logic            pc_we;
  logic            ifid_we;
  logic            idex_we;
  logic            exmem_we;
  logic            ifid_flush;
  logic            idex_flush;
  logic            pc_sel_redirect;
  logic [XLEN-1:0] pc_redirect;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_RegWEn,
           idex_WBsel, ex_redirect, ex_target, mem_req, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           pc_sel_redirect, pc_redirect, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_RegWEn,
           idex_WBsel, ex_redirect, ex_target, mem_req, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
           pc_sel_redirect, pc_redirect, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in ID/EX and the consumer in IF/ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rd,
  input  logic       reg_wen,
  input  logic [1:0] wb_sel,
  output logic       lu
);
  logic is_load;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign is_load = reg_wen && (wb_sel == WB_MEM) && (rd != 5'd0);
  assign lu      = is_load && (reg_match(rd, rs1, uses_rs1) || reg_match(rd, rs2, uses_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX redirects,
// front-end freeze during data-memory waits, and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  state_t           state, state_d;
  logic             pend, pend_d;
  logic [XLEN-1:0]  redir_q, redir_d;
  logic [XLEN-1:0]  redirect;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu;
  ctrl_t            ctrl, rule_ctrl;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  load_use_detect u_lu (
    .rs1      (bus.ifid_rs1),
    .rs2      (bus.ifid_rs2),
    .uses_rs1 (bus.ifid_uses_rs1),
    .uses_rs2 (bus.ifid_uses_rs2),
    .rd       (bus.idex_rd),
    .reg_wen  (bus.idex_RegWEn),
    .wb_sel   (bus.idex_WBsel),
    .lu       (lu)
  );

  // Redirect outranks load-use: the dependent instruction is being flushed anyway.
  always_comb begin
    if (bus.ex_redirect)
      rule_ctrl = CTRL_REDIR;
    else if (lu)
      rule_ctrl = CTRL_BUBBLE;
    else
      rule_ctrl = CTRL_NORMAL;
  end

  always_comb begin
    ctrl     = CTRL_NORMAL;
    redirect = bus.ex_target;
    state_d  = state;
    pend_d   = pend;
    redir_d  = redir_q;
    if (!reset) begin
      ctrl     = CTRL_RESET;
      redirect = '0;
      state_d  = RUN;
      pend_d   = 1'b0;
      redir_d  = '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            if (bus.ex_redirect) begin
              pend_d  = 1'b1;
              redir_d = bus.ex_target;
            end
          end else begin
            ctrl = rule_ctrl;
          end
        end
        MEM_WAIT: begin
          // EX operands may be re-forwarded while frozen; only the latched target is trusted.
          redirect = redir_q;
          if (!bus.mem_ready) begin
            ctrl = CTRL_FREEZE;
          end else begin
            state_d = RUN;
            if (pend) begin
              ctrl   = CTRL_REDIR;
              pend_d = 1'b0;
            end else begin
              ctrl = rule_ctrl;
              if (bus.ex_redirect)
                redirect = bus.ex_target;
            end
          end
        end
        default: begin
          ctrl    = CTRL_FREEZE;
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      pend    <= 1'b0;
      redir_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state   <= state_d;
      pend    <= pend_d;
      redir_q <= redir_d;
      if (!ctrl.pc_we)
        stall_q <= sat_inc(stall_q);
      if (ctrl.pc_sel)
        flush_q <= sat_inc(flush_q);
    end
  end

  assign bus.pc_we           = ctrl.pc_we;
  assign bus.ifid_we         = ctrl.ifid_we;
  assign bus.idex_we         = ctrl.idex_we;
  assign bus.exmem_we        = ctrl.exmem_we;
  assign bus.ifid_flush      = ctrl.ifid_flush;
  assign bus.idex_flush      = ctrl.idex_flush;
  assign bus.pc_sel_redirect = ctrl.pc_sel;
  assign bus.pc_redirect     = redirect;
  assign bus.stall_cnt       = stall_q;
  assign bus.flush_cnt       = flush_q;

endmodule
